// File: rtl/isp_mosaic_l.sv
// rtl/isp_mosaic_l.sv - RGB to Bayer re-mosaic with 2-cycle pipeline.
// Optional line/frame geometry checker enabled by `define ISP_MOSAIC_GEOM_CHK_EN.
module isp_mosaic_l #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int BAYER  = 0
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic            in_de,
    input  logic [7:0]      in_r,
    input  logic [7:0]      in_g,
    input  logic [7:0]      in_b,
    output logic            out_href,
    output logic            out_vsync,
    output logic            out_de,
    output logic [BITS-1:0] out_raw,
    output logic            line_err,
    output logic            frame_err
);

    localparam logic [1:0] PATTERN = 2'(BAYER);

    logic            prev_href;
    logic            col;
    logic            row;
    logic            href_fall;
    logic [1:0]      fmt;
    logic [7:0]      comp;
    logic [BITS-1:0] comp_x;

    logic            s1_href;
    logic            s1_vsync;
    logic            s1_de;
    logic [BITS-1:0] s1_raw;

    assign href_fall = prev_href & ~in_href;

    // col/row hold the phase of the pixel currently on the inputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            prev_href <= 1'b0;
            col       <= 1'b0;
            row       <= 1'b0;
        end else begin
            prev_href <= in_href;
            col       <= in_href ? ~col : 1'b0;
            if (in_vsync) begin
                row <= 1'b0;
            end else if (href_fall) begin
                row <= ~row;
            end
        end
    end

    always_comb begin
        fmt = PATTERN ^ {row, col};
        case (fmt)
            2'd0:    comp = in_r;
            2'd3:    comp = in_b;
            default: comp = in_g;
        endcase
    end

    // Left-align and refill the low bits with the component MSBs so full scale stays full scale
    generate
        if (BITS == 8) begin : g_exp_8
            assign comp_x = comp;
        end else begin : g_exp_wide
            assign comp_x = {comp, comp[7 -: (BITS - 8)]};
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_href   <= 1'b0;
            s1_vsync  <= 1'b0;
            s1_de     <= 1'b0;
            s1_raw    <= '0;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
            out_raw   <= '0;
        end else begin
            s1_href   <= in_href;
            s1_vsync  <= in_vsync;
            s1_de     <= in_de;
            s1_raw    <= comp_x;
            out_href  <= s1_href;
            out_vsync <= s1_vsync;
            out_de    <= s1_de;
            out_raw   <= s1_href ? s1_raw : '0;
        end
    end

`ifdef ISP_MOSAIC_GEOM_CHK_EN
    localparam logic [15:0] WIDTH_W  = 16'(WIDTH);
    localparam logic [15:0] HEIGHT_W = 16'(HEIGHT);

    logic        prev_vsync;
    logic        seen_vsync;
    logic        vsync_rise;
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic [15:0] line_total;

    assign vsync_rise = in_vsync & ~prev_vsync;

    // A line ending in the same cycle as the vsync rise still belongs to the closing frame
    always_comb begin
        line_total = line_cnt;
        if (href_fall && line_cnt != 16'hFFFF) begin
            line_total = line_cnt + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            prev_vsync <= 1'b0;
            seen_vsync <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            prev_vsync <= in_vsync;
            if (href_fall) begin
                pix_cnt <= '0;
            end else if (in_href && pix_cnt != 16'hFFFF) begin
                pix_cnt <= pix_cnt + 16'd1;
            end
            if (href_fall && pix_cnt != WIDTH_W) begin
                line_err <= 1'b1;
            end else if (in_vsync) begin
                line_err <= 1'b0;
            end
            frame_err <= vsync_rise && seen_vsync && (line_total != HEIGHT_W);
            if (vsync_rise) begin
                line_cnt   <= '0;
                seen_vsync <= 1'b1;
            end else begin
                line_cnt   <= line_total;
            end
        end
    end
`else
    assign line_err  = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule
